// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   muldiv_op_t    - operation encoding presented on the op port
//   muldiv_state_t - sequencing states of muldiv_unit
//   MULDIV_ITER    - add/subtract steps per operation
//   MULDIV_CNT_W   - width of the step counter
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIXUP
  } muldiv_state_t;

  localparam int unsigned MULDIV_ITER  = 32;
  localparam int unsigned MULDIV_CNT_W = 5;

endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: W-bit add/subtract slice shared by the multiply and divide steps.
//   a, b      - operands
//   sub       - 0: a + b, 1: a - b (a + ~b + 1)
//   result    - low W bits of the sum
//   carry_out - carry from bit W-1; for subtraction 1 means a >= b (no borrow)
module muldiv_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         carry_out
);

  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
  end

  assign result    = sum[W-1:0];
  assign carry_out = sum[W];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide unit with its own HI/LO pair.
// One add/subtract step per cycle through a (WIDTH+1)-bit slice; latency 34
// cycles from the start edge, 2 cycles for divide-by-zero.
// Build option: define MULDIV_DIV_EN to implement DIV/DIVU; otherwise divide
// ops complete on the short path with HI/LO unchanged and no flag.
// Ports:
//   clk, reset (async, active-high)
//   start, op, operand_a, operand_b - launch an operation (honoured in IDLE)
//   mthi, mtlo, wdata                - direct HI/LO writes (honoured in IDLE)
//   busy                             - high in every state except IDLE
//   done, div_by_zero                - registered completion pulse and flag
//   hi, lo                           - registered HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t           state_q, state_d;
  muldiv_op_t              op_q, op_d;
  logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
  // hw: accumulator (mult) / partial remainder (div)
  // lw: multiplier (mult) / dividend shifting into quotient (div)
  // addend: multiplicand (mult) / divisor (div)
  logic [WIDTH-1:0]        hw_q, hw_d, lw_q, lw_d, addend_q, addend_d;
  logic                    neg_q, neg_d;
  logic                    skip_q, skip_d;
  logic                    done_q, done_d;
  logic                    dbz_q, dbz_d;
  logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;
`ifdef MULDIV_DIV_EN
  logic                    rem_neg_q, rem_neg_d;
`endif

  logic                    is_div, is_signed;
  logic [WIDTH-1:0]        mag_a, mag_b;
  logic [WIDTH:0]          add_a, add_b, add_res, step_t;
  logic                    add_co;
  logic [2*WIDTH-1:0]      prod;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // Divide shifts the next dividend bit into the trial remainder before subtracting.
  assign add_a = is_div ? {hw_q, lw_q[WIDTH-1]} : {1'b0, hw_q};
  assign add_b = {1'b0, addend_q};

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .a         (add_a),
    .b         (add_b),
    .sub       (is_div),
    .result    (add_res),
    .carry_out (add_co)
  );

`ifndef MULDIV_DIV_EN
  logic unused_add_co;
  assign unused_add_co = add_co;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hw_d     = hw_q;
    lw_d     = lw_q;
    addend_d = addend_q;
    neg_d    = neg_q;
    skip_d   = skip_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULDIV_DIV_EN
    rem_neg_d = rem_neg_q;
`endif
    mag_a  = (is_signed && addend_q[WIDTH-1]) ? -addend_q : addend_q;
    mag_b  = (is_signed && lw_q[WIDTH-1]) ? -lw_q : lw_q;
    step_t = lw_q[0] ? add_res : {1'b0, hw_q};
    prod   = neg_q ? -{hw_q, lw_q} : {hw_q, lw_q};

    unique case (state_q)
      ST_IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          state_d  = ST_PREP;
          op_d     = muldiv_op_t'(op);
          addend_d = operand_a;   // raw operands parked until PREP
          lw_d     = operand_b;
        end
      end
      ST_PREP: begin
        neg_d = is_signed & (addend_q[WIDTH-1] ^ lw_q[WIDTH-1]);
        hw_d  = '0;
        cnt_d = MULDIV_CNT_W'(MULDIV_ITER - 1);
        if (is_div) begin
`ifdef MULDIV_DIV_EN
          rem_neg_d = is_signed & addend_q[WIDTH-1];
          addend_d  = mag_b;
          lw_d      = mag_a;
          skip_d    = (lw_q == '0);
          state_d   = (lw_q == '0) ? ST_FIXUP : ST_RUN;
`else
          skip_d    = 1'b1;
          state_d   = ST_FIXUP;
`endif
        end else begin
          addend_d = mag_a;
          lw_d     = mag_b;
          skip_d   = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
`ifdef MULDIV_DIV_EN
        if (is_div) begin
          if (add_co) begin
            hw_d = add_res[WIDTH-1:0];
            lw_d = {lw_q[WIDTH-2:0], 1'b1};
          end else begin
            hw_d = add_a[WIDTH-1:0];
            lw_d = {lw_q[WIDTH-2:0], 1'b0};
          end
        end else
`endif
        begin
          hw_d = step_t[WIDTH:1];
          lw_d = {step_t[0], lw_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = ST_FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIXUP: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (skip_q) begin
`ifdef MULDIV_DIV_EN
          dbz_d = 1'b1;
`endif
        end else if (is_div) begin
`ifdef MULDIV_DIV_EN
          hi_d = rem_neg_q ? -hw_q : hw_q;
          lo_d = neg_q ? -lw_q : lw_q;
`endif
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      hw_q      <= '0;
      lw_q      <= '0;
      addend_q  <= '0;
      neg_q     <= 1'b0;
      skip_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV_EN
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      hw_q      <= hw_d;
      lw_q      <= lw_d;
      addend_q  <= addend_d;
      neg_q     <= neg_d;
      skip_q    <= skip_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Stimulus pushes the
// expected {div_by_zero, hi, lo} computed with plain 64-bit arithmetic; a
// monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [64:0] sb[$];
  logic [64:0] mon_e;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {div_by_zero, hi, lo} from the architectural definition.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, b,
                                        input logic [31:0] hi_in, lo_in);
    longint sa, sb_, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb_ = $signed(b);
    case (o)
      2'b00: begin p = sa * sb_; return {1'b0, p}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      default: begin
        if (!DIV_EN) return {1'b0, hi_in, lo_in};
        if (b == 32'd0) return {1'b1, hi_in, lo_in};
        if (o == 2'b10) begin
          q = sa / sb_;
          r = sa % sb_;
          return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no pending op at %0t", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("hi", 64'(hi), 64'(mon_e[63:32]));
          chk("lo", 64'(lo), 64'(mon_e[31:0]));
          chk("div_by_zero", 64'(div_by_zero), 64'(mon_e[64]));
        end
      end else begin
        chk("dbz_without_done", 64'(div_by_zero), 64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, b,
                        input logic wh, wl, input logic [31:0] wd, input bit inject);
    logic [64:0] e;
    logic [31:0] hi_before, lo_before;
    int unsigned n, exp_lat;
    bit busy_ok;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    mthi = wh; mtlo = wl; wdata = wd;
    if (wh) mdl_hi = wd;
    if (wl) mdl_lo = wd;
    hi_before = mdl_hi;
    lo_before = mdl_lo;
    e = model(o, a, b, mdl_hi, mdl_lo);
    sb.push_back(e);
    mdl_hi = e[63:32];
    mdl_lo = e[31:0];
    exp_lat = (o[1] && (!DIV_EN || b == 32'd0)) ? 2 : 34;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (n == 1 || n == 20) begin
        chk("hi_hold", 64'(hi), 64'(hi_before));
        chk("lo_hold", 64'(lo), 64'(lo_before));
      end
      n++;
      if (inject) begin
        if (n == 5) begin mthi = 1'b1; wdata = 32'hAAAA; end
        if (n == 6) mthi = 1'b0;
        if (n == 10) begin start = 1'b1; op = 2'b01; operand_a = 32'd7; operand_b = 32'd9; end
        if (n == 11) start = 1'b0;
      end
      if (n >= 100) break;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("busy_during_op", 64'(busy_ok), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic mt_write(input logic wh, wl, input logic [31:0] wd);
    mthi = wh; mtlo = wl; wdata = wd;
    if (wh) mdl_hi = wd;
    if (wl) mdl_lo = wd;
    @(posedge clk);
    #1;
    mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    chk("mt_hi", 64'(hi), 64'(mdl_hi));
    chk("mt_lo", 64'(lo), 64'(mdl_lo));
  endtask

  initial begin
    bit any_done;
    logic [1:0] ro;
    logic [31:0] ra, rb, rw;
    logic rwh, rwl;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
    run_op(2'b00, -32'sd3, 32'd7, 1'b0, 1'b0, '0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, '0, 1'b0);
    run_op(2'b10, -32'sd7, 32'd2, 1'b0, 1'b0, '0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    mt_write(1'b1, 1'b0, 32'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    run_op(2'b11, 32'd5, 32'd0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    mt_write(1'b0, 1'b1, 32'h55);
    run_op(2'b01, 32'h1234, 32'h5678, 1'b0, 1'b0, '0, 1'b1);

    // Abort a MULT with reset mid-run.
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'h1234_5678; operand_b = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    mdl_hi = '0;
    mdl_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    any_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    chk("no_done_after_abort", 64'(any_done), 64'd0);
    run_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0, '0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      rwh = ($urandom_range(0, 3) == 0);
      rwl = ($urandom_range(0, 3) == 0);
      rw  = $urandom;
      run_op(ro, ra, rb, rwh, rwl, rw, 1'b0);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
